// File: rtl/rca_pkg.sv
// Shared types and elaboration helpers for the multi-cycle ripple-carry adder.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int unsigned nslice(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  // Counter needs at least one bit even when a single slice covers the word.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple of full adders.
// With RCA_OVF_EN the carry into the MSB is exported for overflow detection.
module rca_slice #(
  parameter int unsigned SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
`ifdef RCA_OVF_EN
  output logic             c_msb,
`endif
  output logic             cout
);

  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SLICE; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SLICE];
`ifdef RCA_OVF_EN
  assign c_msb = c[SLICE-1];
`endif

endmodule

// File: rtl/rca_multicycle.sv
// Multi-cycle ripple-carry adder: one SLICE-bit slice reused over WIDTH/SLICE cycles.
// Optional signed-overflow output enabled by defining RCA_OVF_EN.
module rca_multicycle
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef RCA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
  localparam int unsigned CNTW   = cnt_width(NSLICE);
  localparam logic [CNTW-1:0] LAST = CNTW'(NSLICE - 1);

  if (SLICE == 0 || WIDTH % SLICE != 0) begin : g_bad_width
    $error("rca_multicycle: WIDTH must be a non-zero multiple of SLICE");
  end

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNTW-1:0]  cnt;

  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] acc_next;
`ifdef RCA_OVF_EN
  logic             slice_cmsb;
`endif

  rca_slice #(.SLICE(SLICE)) u_slice (
    .a    (acc[SLICE-1:0]),
    .b    (b_sh[SLICE-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
`ifdef RCA_OVF_EN
    .c_msb(slice_cmsb),
`endif
    .cout (slice_cout)
  );

  // The a shift register doubles as the sum accumulator: each consumed slice
  // of a is replaced at the MSB end by its result, so after NSLICE steps it
  // holds the full sum in order. The visible sum only loads on the last step.
  assign acc_next = (acc >> SLICE) | (WIDTH'(slice_sum) << (WIDTH - SLICE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc       <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef RCA_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          b_sh  <= b_sh >> SLICE;
          carry <= slice_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum       <= acc_next;
            cout      <= slice_cout;
`ifdef RCA_OVF_EN
            ovf       <= slice_cmsb ^ slice_cout;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
